// File: rtl/tx_link_arbiter_if.sv
// Signal bundle between the packet sources, the tx_link_arbiter and the serial transmitter.
// The master modport is the arbiter's view. The slave modport is the view of the sources and transmitter.
interface tx_link_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 55
);
  logic [NUM_REQ-1:0]        Req_Valid;
  logic [NUM_REQ*DATA_W-1:0] Req_Data;
  logic [NUM_REQ-1:0]        Req_Ack;
  logic [NUM_REQ-1:0]        Grant;
  logic [DATA_W-1:0]         TX_Data;
  logic                      TX_Data_Valid;
  logic                      TX_Ready;
  logic                      Busy;
  logic                      Tmo_Err;
  logic [15:0]               Sent_Count;

  modport master (
    input  Req_Valid, Req_Data, TX_Ready,
    output Req_Ack, Grant, TX_Data, TX_Data_Valid, Busy, Tmo_Err, Sent_Count
  );

  modport slave (
    output Req_Valid, Req_Data, TX_Ready,
    input  Req_Ack, Grant, TX_Data, TX_Data_Valid, Busy, Tmo_Err, Sent_Count
  );
endinterface

// File: rtl/tx_link_arbiter.sv
// Round-robin arbiter that hands one serial transmitter to NUM_REQ packet sources.
// It sends one packet per grant: launch, wait for busy, wait for idle, with a timeout on launch.
module tx_link_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 55,
  parameter int LAUNCH_TMO = 16
) (
  input  logic                Clk_S,
  input  logic                Rst,
  tx_link_arbiter_if.master   lnk
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(LAUNCH_TMO);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LAUNCH_TMO - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    tx_data_p1, tx_data_p0;
  logic                 vld_p1, vld_p0;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;
  logic [15:0]          sent_count_q, sent_count_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
  logic [DATA_W-1:0]    sel_data;

  // Rotating search: the first requester after the last owner wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && lnk.Req_Valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign sel_data = lnk.Req_Data[int'(win_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    grant_d      = grant_q;
    ack_d        = '0;
    tx_data_p0   = tx_data_p1;
    vld_p0       = vld_p1;
    tmo_d        = tmo_q;
    sent_count_d = sent_count_q;
    unique case (state_q)
      IDLE: begin
        if (lnk.TX_Ready && win_found) begin
          idx_d      = win_idx;
          tx_data_p0 = sel_data;
          grant_d    = NUM_REQ'(1) << win_idx;
          vld_p0     = 1'b1;
          tmr_d      = '0;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!lnk.TX_Ready) begin
          ack_d        = NUM_REQ'(1) << idx_q;
          sent_count_d = sent_count_q + 16'd1;
          vld_p0       = 1'b0;
          state_d      = WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          // Give up on this launch and restart the rotation after the failed requester.
          tmo_d   = 1'b1;
          vld_p0  = 1'b0;
          grant_d = '0;
          ptr_d   = idx_q;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (lnk.TX_Ready) begin
          ptr_d   = idx_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_RST;
      idx_q        <= '0;
      tmr_q        <= '0;
      grant_q      <= '0;
      ack_q        <= '0;
      tx_data_p1   <= '0;
      vld_p1       <= 1'b0;
      busy_q       <= 1'b0;
      tmo_q        <= 1'b0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      tx_data_p1   <= tx_data_p0;
      vld_p1       <= vld_p0;
      busy_q       <= busy_d;
      tmo_q        <= tmo_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign lnk.Grant         = grant_q;
  assign lnk.Req_Ack       = ack_q;
  assign lnk.TX_Data       = tx_data_p1;
  assign lnk.TX_Data_Valid = vld_p1;
  assign lnk.Busy          = busy_q;
  assign lnk.Tmo_Err       = tmo_q;
  assign lnk.Sent_Count    = sent_count_q;

endmodule

// File: tb/tb_tx_link_arbiter.sv
// Directed bench for tx_link_arbiter: reset, single transfer, rotation, launch timeout,
// reset during WAIT_DONE and Sent_Count wrap, each step checked against hand-computed values.
module tb_tx_link_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 55;
  localparam int LAUNCH_TMO = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  tx_link_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) lnk();

  tx_link_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LAUNCH_TMO(LAUNCH_TMO)) dut (
    .Clk_S (clk),
    .Rst   (rst),
    .lnk   (lnk)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (lnk.TX_Data_Valid !== 1'b1 && lat < 40);
    chk({tag, "_launch"}, 64'(lnk.TX_Data_Valid), 64'(1'b1));
  endtask

  // One complete transfer with a well-behaved transmitter model.
  task automatic xfer(input string tag, input int dly, input int busy_len,
                      input logic [3:0] g, input logic [54:0] d, input logic [15:0] cnt,
                      input bit drop, output int lat);
    int acks;
    wait_valid(tag, lat);
    chk({tag, "_grant"}, 64'(lnk.Grant), 64'(g));
    chk({tag, "_data"}, 64'(lnk.TX_Data), 64'(d));
    repeat (dly - 1) tick();
    lnk.TX_Ready = 1'b0;
    tick();
    chk({tag, "_ack"}, 64'(lnk.Req_Ack), 64'(g));
    chk({tag, "_count"}, 64'(lnk.Sent_Count), 64'(cnt));
    chk({tag, "_vld_off"}, 64'(lnk.TX_Data_Valid), 64'(1'b0));
    if (drop) lnk.Req_Valid = lnk.Req_Valid & ~g;
    acks = 0;
    repeat (busy_len) begin
      tick();
      if (lnk.Req_Ack !== 4'b0000) acks++;
    end
    chk({tag, "_extra_acks"}, 64'(acks), 64'(0));
    chk({tag, "_grant_held"}, 64'(lnk.Grant), 64'(g));
    lnk.TX_Ready = 1'b1;
    tick();
    chk({tag, "_grant_rel"}, 64'(lnk.Grant), 64'(4'b0000));
    chk({tag, "_idle"}, 64'(lnk.Busy), 64'(1'b0));
  endtask

  initial begin
    logic [54:0] exp_d [4];
    int lat, hi, ackseen;

    exp_d[0] = 55'd10;
    exp_d[1] = 55'd11;
    exp_d[2] = 55'd3;
    exp_d[3] = 55'd13;

    // Reset with every requester active
    rst           = 1'b1;
    lnk.Req_Valid = 4'hF;
    lnk.Req_Data  = {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
    lnk.TX_Ready  = 1'b1;
    repeat (3) tick();
    chk("rst_grant", 64'(lnk.Grant), 64'(4'b0000));
    chk("rst_ack", 64'(lnk.Req_Ack), 64'(4'b0000));
    chk("rst_vld", 64'(lnk.TX_Data_Valid), 64'(1'b0));
    chk("rst_data", 64'(lnk.TX_Data), 64'(55'd0));
    chk("rst_busy", 64'(lnk.Busy), 64'(1'b0));
    chk("rst_tmo", 64'(lnk.Tmo_Err), 64'(1'b0));
    chk("rst_count", 64'(lnk.Sent_Count), 64'(16'd0));
    rst = 1'b0;
    tick();
    chk("first_grant", 64'(lnk.Grant), 64'(4'b0001));
    chk("first_vld", 64'(lnk.TX_Data_Valid), 64'(1'b1));
    chk("first_data", 64'(lnk.TX_Data), 64'(55'd10));
    chk("first_busy", 64'(lnk.Busy), 64'(1'b1));

    // Reset during LAUNCH abandons the grant without an ack
    rst = 1'b1;
    tick();
    chk("rstl_grant", 64'(lnk.Grant), 64'(4'b0000));
    chk("rstl_ack", 64'(lnk.Req_Ack), 64'(4'b0000));
    chk("rstl_vld", 64'(lnk.TX_Data_Valid), 64'(1'b0));
    chk("rstl_busy", 64'(lnk.Busy), 64'(1'b0));
    chk("rstl_count", 64'(lnk.Sent_Count), 64'(16'd0));

    // Single requester 2, transmitter busy for 60 cycles
    rst           = 1'b0;
    lnk.Req_Valid = 4'b0100;
    xfer("t2", 2, 60, 4'b0100, 55'd3, 16'd1, 1'b1, lat);
    chk("t2_latency", 64'(lat), 64'(1));
    chk("t2_valid_dropped", 64'(lnk.Req_Valid), 64'(4'b0000));

    // Rotation with all four requesters persistent, starting from reset
    rst           = 1'b1;
    lnk.Req_Valid = 4'hF;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xfer($sformatf("t3_%0d", i), 1, 3, 4'(1 << (i % 4)), exp_d[i % 4], 16'(i + 1), 1'b0, lat);
    end
    lnk.Req_Valid = 4'b0000;

    // Transmitter never accepts: 16 cycles of valid, then timeout
    lnk.Req_Valid = 4'b0010;
    wait_valid("t4", lat);
    chk("t4_grant", 64'(lnk.Grant), 64'(4'b0010));
    chk("t4_data", 64'(lnk.TX_Data), 64'(55'd11));
    hi      = 0;
    ackseen = 0;
    while (lnk.TX_Data_Valid === 1'b1 && hi < 40) begin
      hi++;
      if (lnk.Req_Ack !== 4'b0000) ackseen++;
      tick();
    end
    chk("t4_valid_cycles", 64'(hi), 64'(LAUNCH_TMO));
    chk("t4_tmo", 64'(lnk.Tmo_Err), 64'(1'b1));
    chk("t4_grant_clr", 64'(lnk.Grant), 64'(4'b0000));
    chk("t4_busy", 64'(lnk.Busy), 64'(1'b0));
    chk("t4_no_ack", 64'(ackseen + int'(lnk.Req_Ack)), 64'(0));
    chk("t4_count", 64'(lnk.Sent_Count), 64'(16'd8));
    // Search restarts after requester 1, so requester 2 wins over 1
    lnk.Req_Valid = 4'b0110;
    xfer("t4b", 1, 3, 4'b0100, 55'd3, 16'd9, 1'b1, lat);
    xfer("t4c", 1, 3, 4'b0010, 55'd11, 16'd10, 1'b1, lat);
    chk("t4_tmo_sticky", 64'(lnk.Tmo_Err), 64'(1'b1));

    // Reset while in WAIT_DONE
    lnk.Req_Valid = 4'b0001;
    wait_valid("t5", lat);
    chk("t5_grant", 64'(lnk.Grant), 64'(4'b0001));
    lnk.TX_Ready = 1'b0;
    tick();
    chk("t5_ack", 64'(lnk.Req_Ack), 64'(4'b0001));
    chk("t5_count", 64'(lnk.Sent_Count), 64'(16'd11));
    lnk.Req_Valid = 4'b0000;
    rst           = 1'b1;
    tick();
    chk("t5_grant_rst", 64'(lnk.Grant), 64'(4'b0000));
    chk("t5_busy_rst", 64'(lnk.Busy), 64'(1'b0));
    chk("t5_ack_rst", 64'(lnk.Req_Ack), 64'(4'b0000));
    chk("t5_tmo_rst", 64'(lnk.Tmo_Err), 64'(1'b0));
    chk("t5_count_rst", 64'(lnk.Sent_Count), 64'(16'd0));
    chk("t5_vld_rst", 64'(lnk.TX_Data_Valid), 64'(1'b0));
    rst          = 1'b0;
    lnk.TX_Ready = 1'b1;
    tick();

    // Counter preset to 0xFFFF in place of 65535 real transfers, then one more wraps it
    force dut.sent_count_d = 16'hFFFF;
    tick();
    release dut.sent_count_d;
    chk("t6_preset", 64'(lnk.Sent_Count), 64'(16'hFFFF));
    lnk.Req_Valid = 4'b0001;
    xfer("t6", 1, 3, 4'b0001, 55'd10, 16'h0000, 1'b1, lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
